mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the data bus.
REQ-002 Parameter ADDR_W, default 32, width of the address bus.
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive data grants allowed while fetch waits.
REQ-004 Ports shall be as follows.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_rd  in  1  data read request; held until d_valid.
- d_wr  in  1  data write request; held until d_valid.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write payload.
- d_rdata  out  DATA_W  data read result.
- d_valid  out  1  one-cycle data completion pulse.
- mem_req  out  1  request to the single-ported memory controller.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from the memory controller.
- if_stall  out  1  if_req & ~if_valid.
- d_stall  out  1  (d_rd | d_wr) & ~d_valid.
- err  out  1  sticky flag; set when d_rd and d_wr are sampled high together.

Function
REQ-005 The FSM shall have three states: IDLE, FETCH, DATA.
REQ-006 In IDLE with a data request pending, the FSM shall go to DATA; otherwise, with if_req high, it shall go to FETCH; otherwise it shall stay in IDLE.
REQ-007 mem_req, mem_we, mem_addr and mem_wdata shall be registered: they are driven from the cycle after the grant edge and held stable until the mem_ack cycle.
REQ-008 In FETCH: mem_we=0 and mem_addr=if_addr latched at grant.
REQ-009 In DATA: mem_we=d_wr, and mem_addr and mem_wdata are latched from d_addr and d_wdata at grant.
REQ-010 On mem_ack, the arbiter shall register mem_rdata into the granted requester's rdata and pulse its valid for exactly one cycle, in the cycle after the ack.
REQ-011 On mem_ack, the FSM shall return to IDLE and mem_req shall deassert on the same edge.
REQ-012 Minimum turnaround is 1 IDLE cycle between transactions.
REQ-013 For a write, d_valid shall pulse and d_rdata shall hold its previous value.
REQ-014 mem_ack received in IDLE shall be ignored: no valid pulse and no state change.
REQ-015 if_rdata and d_rdata shall hold their value until the next completion for the same requester.
REQ-016 If d_rd and d_wr are high together at grant, the transaction shall be treated as a write and err shall be set.
REQ-017 A request that drops before completion is a protocol violation; the transaction in flight shall still complete and its valid shall still pulse.
REQ-018 Minimum latency shall be 3 cycles from request to valid pulse: request, grant edge, mem_ack in the first mem_req cycle, then the valid pulse.

Reset
REQ-019 While rst is high at a clock edge, the following shall be cleared: state to IDLE; mem_req, mem_we, if_valid, d_valid and err to 0; mem_addr, mem_wdata, if_rdata and d_rdata to 0; starvation counter to 0.
REQ-020 A reset asserted mid-transaction shall abandon that transaction; an ack arriving after reset shall be ignored per REQ-014.

Configuration
REQ-021 Macro ARB_STARVE_GUARD_EN, when defined, shall add a counter of consecutive DATA grants made while if_req is high.
- When the counter equals STARVE_LIMIT, the next IDLE decision shall grant FETCH even if a data request is pending.
- The counter shall clear on any FETCH grant, or on a DATA grant made while if_req is low.
REQ-022 Without ARB_STARVE_GUARD_EN, data shall always have strict priority and no counter logic shall be present.

Verification
REQ-023 Single fetch: if_req=1, if_addr=0x100; memory acks in the first mem_req cycle with 0xDEADBEEF -> if_valid pulses once, 3 cycles after the request; if_rdata=0xDEADBEEF.
REQ-024 Simultaneous requests: if_req=1 and d_rd=1 in the same cycle, d_addr=0x200 -> data is served first (mem_addr=0x200), then fetch; d_valid precedes if_valid.
REQ-025 Write with a 5-cycle ack delay: d_wr=1, d_wdata=0x55AA -> mem_req, mem_we=1 and mem_wdata=0x55AA are stable for 5 cycles; d_valid pulses once; d_rdata is unchanged.
REQ-026 Reset mid-transaction: rst asserted during DATA with an ack 2 cycles later -> mem_req=0 after the reset edge, no d_valid pulse, state IDLE.
REQ-027 Both d_rd and d_wr high -> mem_we=1 and err=1; err stays set until rst.
REQ-028 With ARB_STARVE_GUARD_EN, continuous data requests and if_req held, STARVE_LIMIT=4 -> the 5th grant goes to FETCH. Without the macro -> if_valid never pulses while data requests persist.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-controller signals seen by mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              if_stall;
  logic              d_stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           if_stall, d_stall, err
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           if_stall, d_stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported memory controller.
// Define ARB_STARVE_GUARD_EN to bound how long fetch can be starved by back-to-back data.
module mem_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              d_valid_q;
  logic              err_q;

  logic d_pend;
  logic idle_ready;
  logic grant_data;
  logic grant_fetch;

  assign d_pend = bus.d_rd | bus.d_wr;

  // The cycle carrying a valid pulse is the mandatory turnaround: no grant is made in it,
  // so a requester that still holds its request while seeing valid is not re-served.
  assign idle_ready = (state_q == StIdle) & ~if_valid_q & ~d_valid_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

  logic [CntW-1:0] starve_cnt_q;
  logic            starved;

  assign starved    = (starve_cnt_q == CntW'(STARVE_LIMIT));
  assign grant_data = idle_ready & d_pend & ~(starved & bus.if_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (grant_data) begin
      starve_cnt_q <= bus.if_req ? starve_cnt_q + 1'b1 : '0;
    end else if (grant_fetch) begin
      starve_cnt_q <= '0;
    end
  end
`else
  logic unused_starve_limit;

  assign unused_starve_limit = ^STARVE_LIMIT;
  assign grant_data          = idle_ready & d_pend;
`endif

  assign grant_fetch = idle_ready & ~grant_data & bus.if_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (bus.d_rd & bus.d_wr) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // An ack arriving here belongs to no transaction and is dropped.
          if (grant_data) begin
            state_q     <= StData;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_wr;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end else if (grant_fetch) begin
            state_q    <= StFetch;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
          end
        end
        StFetch: begin
          if (bus.mem_ack) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdata_q <= bus.mem_rdata;
            if_valid_q <= 1'b1;
          end
        end
        StData: begin
          if (bus.mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_we_q) begin
              d_rdata_q <= bus.mem_rdata;
            end
            d_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.d_stall   = d_pend & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectation for the starvation case
// follows ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   grants;
  int   fetch_at;
  int   ifv_seen;
  bit   got;

  mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_valids", 32'({bus.if_valid, bus.d_valid}), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, ack in the first mem_req cycle.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    @(negedge clk);
    check("f_mem_req", 32'(bus.mem_req), 32'h1);
    check("f_mem_we", 32'(bus.mem_we), 32'h0);
    check("f_mem_addr", bus.mem_addr, 32'h100);
    check("f_stall", 32'(bus.if_stall), 32'h1);
    check("f_no_early_valid", 32'(bus.if_valid), 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("f_valid", 32'(bus.if_valid), 32'h1);
    check("f_rdata", bus.if_rdata, 32'hDEADBEEF);
    check("f_req_drop", 32'(bus.mem_req), 32'h0);
    check("f_stall_clear", 32'(bus.if_stall), 32'h0);
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);
    check("f_valid_once", 32'(bus.if_valid), 32'h0);

    // Simultaneous fetch and data read: data first.
    bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.d_rd = 1'b1; bus.d_addr = 32'h200;
    @(negedge clk);
    check("s_data_first", bus.mem_addr, 32'h200);
    check("s_data_we", 32'(bus.mem_we), 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11112222;
    @(negedge clk);
    check("s_d_valid", 32'(bus.d_valid), 32'h1);
    check("s_d_rdata", bus.d_rdata, 32'h11112222);
    check("s_if_not_yet", 32'(bus.if_valid), 32'h0);
    bus.mem_ack = 1'b0; bus.d_rd = 1'b0;
    @(negedge clk);
    check("s_turnaround", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    check("s_fetch_req", 32'(bus.mem_req), 32'h1);
    check("s_fetch_addr", bus.mem_addr, 32'h300);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h33334444;
    @(negedge clk);
    check("s_if_valid", 32'(bus.if_valid), 32'h1);
    check("s_if_rdata", bus.if_rdata, 32'h33334444);
    check("s_d_rdata_hold", bus.d_rdata, 32'h11112222);
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);

    // Write with the ack delayed to the fifth mem_req cycle.
    bus.d_wr = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h55AA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("w_hold", 32'({bus.mem_req, bus.mem_we, bus.d_valid}), 32'h6);
      check("w_wdata", bus.mem_wdata, 32'h55AA);
      if (i == 4) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD;
      end
    end
    @(negedge clk);
    check("w_d_valid", 32'(bus.d_valid), 32'h1);
    check("w_rdata_kept", bus.d_rdata, 32'h11112222);
    bus.mem_ack = 1'b0; bus.d_wr = 1'b0;
    @(negedge clk);
    check("w_valid_once", 32'(bus.d_valid), 32'h0);

    // Reset during DATA; a late ack must be ignored.
    bus.d_rd = 1'b1; bus.d_addr = 32'h80;
    @(negedge clk);
    check("r_in_data", 32'(bus.mem_req), 32'h1);
    rst = 1'b1; bus.d_rd = 1'b0;
    @(negedge clk);
    check("r_req_cleared", 32'(bus.mem_req), 32'h0);
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBEEF;
    @(negedge clk);
    check("r_ack_ignored", 32'({bus.mem_req, bus.d_valid}), 32'h0);
    check("r_rdata_zero", bus.d_rdata, 32'h0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("r_still_idle", 32'({bus.mem_req, bus.d_valid, bus.if_valid}), 32'h0);

    // Read and write together: treated as a write, err sticks until reset.
    bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'h77;
    @(negedge clk);
    check("e_mem_we", 32'(bus.mem_we), 32'h1);
    check("e_err", 32'(bus.err), 32'h1);
    check("e_d_stall", 32'(bus.d_stall), 32'h1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h99;
    @(negedge clk);
    check("e_d_valid", 32'(bus.d_valid), 32'h1);
    check("e_rdata_kept", bus.d_rdata, 32'h0);
    bus.mem_ack = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("e_err_sticky", 32'(bus.err), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("e_err_reset", 32'(bus.err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Continuous data reads with fetch pending.
    bus.if_req = 1'b1; bus.if_addr = 32'h900; bus.d_rd = 1'b1; bus.d_addr = 32'hA00;
    grants = 0; fetch_at = 0; ifv_seen = 0;
    for (int cyc = 0; cyc < 80 && fetch_at == 0 && grants < 8; cyc++) begin
      @(negedge clk);
      if (bus.if_valid) ifv_seen++;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        grants++;
        if (bus.mem_addr == 32'h900) fetch_at = grants;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'(grants);
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_fetch_grant", 32'(fetch_at), 32'd5);
`else
    check("starve_no_fetch", 32'(fetch_at), 32'd0);
    check("starve_data_grants", 32'(grants), 32'd8);
`endif
    check("starve_no_if_valid", 32'(ifv_seen), 32'd0);
    bus.d_rd = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        got = 1'b1;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hF00D;
      end
    end
    check("starve_fetch_done", 32'(got), 32'h1);
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
